// File: rtl/dds_ddc_center_dlm_pkg.sv
// Shared types and constants for the DDC centre deadlock watchdog.
package dds_ddc_center_dlm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COUNT   = 2'd1,
    ST_BLOCKED = 2'd2
  } dlm_state_e;

  localparam int EPISODE_W    = 8;
  localparam int DEF_N_AXIS   = 2;
  localparam int DEF_N_INST   = 1;
  localparam int DEF_THRESH_W = 16;

endpackage

// File: rtl/dds_ddc_center_deadlock_watch_if.sv
// Stall/idle inputs, configuration and status outputs of the deadlock watchdog.
interface dds_ddc_center_deadlock_watch_if
  import dds_ddc_center_dlm_pkg::*;
#(
  parameter int N_AXIS   = DEF_N_AXIS,
  parameter int N_INST   = DEF_N_INST,
  parameter int THRESH_W = DEF_THRESH_W
) ();

  logic [N_AXIS-1:0]        axis_block_sigs;
  logic [N_INST-1:0]        inst_idle_sigs;
  logic [N_INST-1:0]        inst_block_sigs;
  logic [THRESH_W-1:0]      threshold;
  logic                     clear;
  logic                     block;
  logic                     block_sticky;
  logic [N_AXIS+N_INST-1:0] src_mask;
  logic [EPISODE_W-1:0]     episode_cnt;

  // The observed datapath side drives stall indications and reads status.
  modport master (
    output axis_block_sigs, inst_idle_sigs, inst_block_sigs, threshold, clear,
    input  block, block_sticky, src_mask, episode_cnt
  );

  modport slave (
    input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, threshold, clear,
    output block, block_sticky, src_mask, episode_cnt
  );

endinterface

// File: rtl/dds_ddc_center_dlm_persist.sv
// Persistence counter: counts consecutive cycles with raw high and flags when
// the next sample would reach the effective threshold (0 behaves as 1).
module dds_ddc_center_dlm_persist
  import dds_ddc_center_dlm_pkg::*;
#(
  parameter int THRESH_W = DEF_THRESH_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                raw,
  input  logic [THRESH_W-1:0] threshold,
  output logic                reach
);

  logic [THRESH_W-1:0] cnt_q;
  logic [THRESH_W-1:0] cnt_inc;
  logic [THRESH_W-1:0] thresh_eff;

  function automatic logic [THRESH_W-1:0] sat_inc(input logic [THRESH_W-1:0] v);
    return (&v) ? v : v + THRESH_W'(1);
  endfunction

  // Threshold is live every cycle; >= keeps a lowered threshold from being
  // skipped over while a burst is already in progress.
  always_comb begin
    cnt_inc    = sat_inc(cnt_q);
    thresh_eff = (threshold == '0) ? THRESH_W'(1) : threshold;
    reach      = raw && (cnt_inc >= thresh_eff);
  end

  always_ff @(posedge clock) begin
    if (reset || !raw) cnt_q <= '0;
    else               cnt_q <= cnt_inc;
  end

endmodule

// File: rtl/dds_ddc_center_deadlock_watch.sv
// Deadlock watchdog: flags stall sources persisting for threshold cycles.
// Define DDS_DDC_DEADLOCK_SNAPSHOT_EN to latch which sources caused the first episode.
module dds_ddc_center_deadlock_watch
  import dds_ddc_center_dlm_pkg::*;
#(
  parameter int N_AXIS   = DEF_N_AXIS,
  parameter int N_INST   = DEF_N_INST,
  parameter int THRESH_W = DEF_THRESH_W
) (
  input  logic                            clock,
  input  logic                            reset,
  dds_ddc_center_deadlock_watch_if.slave  mon
);

  localparam int SRC_W = N_AXIS + N_INST;

  logic [SRC_W-1:0]     raw_src;
  logic                 raw;
  logic                 reach;
  dlm_state_e           state_q;
  dlm_state_e           state_d;
  logic                 block;
  logic                 enter;
  logic                 sticky_q;
  logic [EPISODE_W-1:0] ep_q;

  function automatic logic [EPISODE_W-1:0] ep_sat_inc(input logic [EPISODE_W-1:0] v);
    return (&v) ? v : v + EPISODE_W'(1);
  endfunction

  // An instance that reports idle is not considered blocked.
  assign raw_src = {mon.inst_block_sigs & ~mon.inst_idle_sigs, mon.axis_block_sigs};
  assign raw     = |raw_src;

  dds_ddc_center_dlm_persist #(
    .THRESH_W (THRESH_W)
  ) u_persist (
    .clock     (clock),
    .reset     (reset),
    .raw       (raw),
    .threshold (mon.threshold),
    .reach     (reach)
  );

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    state_d = raw ? (reach ? ST_BLOCKED : ST_COUNT) : ST_IDLE;
      ST_COUNT:   state_d = !raw ? ST_IDLE : (reach ? ST_BLOCKED : ST_COUNT);
      ST_BLOCKED: state_d = raw ? ST_BLOCKED : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    block = 1'b0;
    enter = 1'b0;
    block = (state_q == ST_BLOCKED);
    enter = (state_q != ST_BLOCKED) && (state_d == ST_BLOCKED);
  end

  // A new episode on the clearing edge wins over the clear.
  always_ff @(posedge clock) begin
    if (reset)           sticky_q <= 1'b0;
    else if (enter)      sticky_q <= 1'b1;
    else if (mon.clear)  sticky_q <= 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset)          ep_q <= '0;
    else if (mon.clear) ep_q <= enter ? EPISODE_W'(1) : '0;
    else if (enter)     ep_q <= ep_sat_inc(ep_q);
  end

`ifdef DDS_DDC_DEADLOCK_SNAPSHOT_EN
  logic [SRC_W-1:0] snap_q;

  // Only the first episode after a clear is captured; sticky marks it taken.
  always_ff @(posedge clock) begin
    if (reset)                                  snap_q <= '0;
    else if (enter && (mon.clear || !sticky_q)) snap_q <= raw_src;
    else if (mon.clear)                         snap_q <= '0;
  end

  assign mon.src_mask = snap_q;
`else
  assign mon.src_mask = '0;
`endif

  assign mon.block        = block;
  assign mon.block_sticky = sticky_q;
  assign mon.episode_cnt  = ep_q;

endmodule

// File: tb/tb_dds_ddc_center_deadlock_watch.sv
// Scoreboard bench for the deadlock watchdog (N_AXIS=2, N_INST=1, THRESH_W=16).
module tb_dds_ddc_center_deadlock_watch;

  typedef struct packed {
    logic       b;
    logic       s;
    logic [2:0] m;
    logic [7:0] e;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  exp_t q[$];

  dds_ddc_center_deadlock_watch_if #(.N_AXIS(2), .N_INST(1), .THRESH_W(16)) bus ();

  dds_ddc_center_deadlock_watch #(
    .N_AXIS   (2),
    .N_INST   (1),
    .THRESH_W (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .mon   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [2:0] mx(input logic [2:0] v);
`ifdef DDS_DDC_DEADLOCK_SNAPSHOT_EN
    return v;
`else
    return 3'b000;
`endif
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // One stimulus cycle; expected outputs after the following rising edge.
  task automatic cyc(input logic [1:0] ax, input logic idl, input logic ib,
                     input logic [15:0] th, input logic cl, input logic rs,
                     input logic eb, input logic es, input logic [2:0] em,
                     input logic [7:0] ee);
    exp_t x;
    @(negedge clock);
    bus.axis_block_sigs = ax;
    bus.inst_idle_sigs  = idl;
    bus.inst_block_sigs = ib;
    bus.threshold       = th;
    bus.clear           = cl;
    reset               = rs;
    @(posedge clock);
    #1;
    x.b = eb; x.s = es; x.m = mx(em); x.e = ee;
    q.push_back(x);
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      chk("block",        {7'd0, bus.block},        {7'd0, x.b});
      chk("block_sticky", {7'd0, bus.block_sticky}, {7'd0, x.s});
      chk("src_mask",     {5'd0, bus.src_mask},     {5'd0, x.m});
      chk("episode_cnt",  bus.episode_cnt,          x.e);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.axis_block_sigs = '0;
    bus.inst_idle_sigs  = '0;
    bus.inst_block_sigs = '0;
    bus.threshold       = 16'd1;
    bus.clear           = 1'b0;

    // Reset state
    cyc(2'b00, 0, 0, 16'd1, 0, 1, 0, 0, 3'b000, 8'd0);
    cyc(2'b00, 0, 0, 16'd1, 0, 1, 0, 0, 3'b000, 8'd0);

    // Threshold 1, single-cycle stall: one-cycle block one edge later
    cyc(2'b01, 0, 0, 16'd1, 0, 0, 1, 1, 3'b001, 8'd1);
    cyc(2'b00, 0, 0, 16'd1, 0, 0, 0, 1, 3'b001, 8'd1);
    cyc(2'b00, 0, 0, 16'd1, 0, 0, 0, 1, 3'b001, 8'd1);
    cyc(2'b00, 0, 0, 16'd1, 1, 0, 0, 0, 3'b000, 8'd0);

    // Threshold 4: 3-cycle burst ignored, 4-cycle burst trips
    for (int i = 0; i < 3; i++) cyc(2'b01, 0, 0, 16'd4, 0, 0, 0, 0, 3'b000, 8'd0);
    cyc(2'b00, 0, 0, 16'd4, 0, 0, 0, 0, 3'b000, 8'd0);
    for (int i = 0; i < 3; i++) cyc(2'b01, 0, 0, 16'd4, 0, 0, 0, 0, 3'b000, 8'd0);
    cyc(2'b01, 0, 0, 16'd4, 0, 0, 1, 1, 3'b001, 8'd1);
    cyc(2'b00, 0, 0, 16'd4, 0, 0, 0, 1, 3'b001, 8'd1);
    cyc(2'b00, 0, 0, 16'd4, 1, 0, 0, 0, 3'b000, 8'd0);

    // Idle instance is not blocked; busy one trips after threshold 3
    for (int i = 0; i < 10; i++) cyc(2'b00, 1, 1, 16'd3, 0, 0, 0, 0, 3'b000, 8'd0);
    cyc(2'b00, 0, 1, 16'd3, 0, 0, 0, 0, 3'b000, 8'd0);
    cyc(2'b00, 0, 1, 16'd3, 0, 0, 0, 0, 3'b000, 8'd0);
    cyc(2'b00, 0, 1, 16'd3, 0, 0, 1, 1, 3'b100, 8'd1);
    cyc(2'b00, 0, 0, 16'd3, 0, 0, 0, 1, 3'b100, 8'd1);

    // Clear coincident with a new entry: entry wins
    cyc(2'b01, 0, 0, 16'd1, 1, 0, 1, 1, 3'b001, 8'd1);
    cyc(2'b00, 0, 0, 16'd1, 0, 0, 0, 1, 3'b001, 8'd1);

    // Snapshot holds first episode's sources until clear
    cyc(2'b00, 0, 0, 16'd2, 1, 0, 0, 0, 3'b000, 8'd0);
    cyc(2'b10, 0, 0, 16'd2, 0, 0, 0, 0, 3'b000, 8'd0);
    cyc(2'b10, 0, 0, 16'd2, 0, 0, 1, 1, 3'b010, 8'd1);
    cyc(2'b00, 0, 0, 16'd2, 0, 0, 0, 1, 3'b010, 8'd1);
    cyc(2'b00, 0, 1, 16'd2, 0, 0, 0, 1, 3'b010, 8'd1);
    cyc(2'b00, 0, 1, 16'd2, 0, 0, 1, 1, 3'b010, 8'd2);
    cyc(2'b00, 0, 0, 16'd2, 0, 0, 0, 1, 3'b010, 8'd2);
    cyc(2'b00, 0, 0, 16'd2, 1, 0, 0, 0, 3'b000, 8'd0);

    // Threshold 0 behaves as 1
    cyc(2'b01, 0, 0, 16'd0, 0, 0, 1, 1, 3'b001, 8'd1);
    cyc(2'b00, 0, 0, 16'd0, 0, 0, 0, 1, 3'b001, 8'd1);

    // Threshold lowered mid-count takes effect immediately
    cyc(2'b01, 0, 0, 16'd5, 0, 0, 0, 1, 3'b001, 8'd1);
    cyc(2'b01, 0, 0, 16'd5, 0, 0, 0, 1, 3'b001, 8'd1);
    cyc(2'b01, 0, 0, 16'd3, 0, 0, 1, 1, 3'b001, 8'd2);
    cyc(2'b00, 0, 0, 16'd3, 0, 0, 0, 1, 3'b001, 8'd2);

    // Reset mid-count discards progress; count restarts from 1
    cyc(2'b01, 0, 0, 16'd3, 0, 0, 0, 1, 3'b001, 8'd2);
    cyc(2'b01, 0, 0, 16'd3, 0, 0, 0, 1, 3'b001, 8'd2);
    cyc(2'b01, 0, 0, 16'd3, 0, 1, 0, 0, 3'b000, 8'd0);
    cyc(2'b01, 0, 0, 16'd3, 0, 0, 0, 0, 3'b000, 8'd0);
    cyc(2'b01, 0, 0, 16'd3, 0, 0, 0, 0, 3'b000, 8'd0);
    cyc(2'b01, 0, 0, 16'd3, 0, 0, 1, 1, 3'b001, 8'd1);
    cyc(2'b00, 0, 0, 16'd3, 1, 0, 0, 0, 3'b000, 8'd0);

    // 300 episodes saturate the counter at 255
    for (int k = 1; k <= 300; k++) begin
      logic [7:0] ee;
      ee = (k > 255) ? 8'd255 : k[7:0];
      cyc(2'b01, 0, 0, 16'd1, 0, 0, 1, 1, 3'b001, ee);
      cyc(2'b00, 0, 0, 16'd1, 0, 0, 0, 1, 3'b001, ee);
    end
    cyc(2'b01, 0, 0, 16'd1, 0, 0, 1, 1, 3'b001, 8'd255);
    // Reset while blocked clears everything, overriding raw
    cyc(2'b01, 0, 0, 16'd1, 0, 1, 0, 0, 3'b000, 8'd0);
    cyc(2'b00, 0, 0, 16'd1, 0, 0, 0, 0, 3'b000, 8'd0);

    @(negedge clock);
    @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dds_ddc_center_deadlock_watch.md
DDS_DDC_CENTER_DEADLOCK_WATCH -- requirements
Module: dds_ddc_center_deadlock_watch

Interface
REQ-001 SHALL have parameter N_AXIS, default 2, number of AXIS block inputs (>=1).
REQ-002 SHALL have parameter N_INST, default 1, number of sub-instance idle/block pairs (>=1).
REQ-003 SHALL have parameter THRESH_W, default 16, width of persistence threshold and counter.
REQ-004 SHALL have port clock  in  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port axis_block_sigs  in  N_AXIS  per-channel AXIS stall indication.
REQ-007 SHALL have port inst_idle_sigs  in  N_INST  sub-instance idle.
REQ-008 SHALL have port inst_block_sigs  in  N_INST  sub-instance blocked.
REQ-009 SHALL have port threshold  in  THRESH_W  consecutive blocked cycles required; 0 treated as 1.
REQ-010 SHALL have port clear  in  1  single-cycle pulse clearing sticky/snapshot state.
REQ-011 SHALL have port block  out  1  live deadlock indication.
REQ-012 SHALL have port block_sticky  out  1  latched deadlock seen since last clear.
REQ-013 SHALL have port src_mask  out  N_AXIS+N_INST  snapshot of blocking sources (bit0 = axis 0, inst bits above axis bits).
REQ-014 SHALL have port episode_cnt  out  8  number of deadlock episodes, saturating at 255.

Function
REQ-015 SHALL form raw_src = {inst_block_sigs & ~inst_idle_sigs, axis_block_sigs}; raw = OR of raw_src.
REQ-016 SHALL run FSM states IDLE, COUNT, BLOCKED.
REQ-017 IDLE: raw=1 and effective threshold=1 -> BLOCKED; raw=1 otherwise -> COUNT with counter=1; raw=0 stays IDLE, counter=0.
REQ-018 COUNT: raw=0 -> IDLE, counter=0; raw=1 -> counter+1; when counter+1 equals effective threshold -> BLOCKED.
REQ-019 BLOCKED: raw=0 -> IDLE, counter=0; raw=1 stays BLOCKED.
REQ-020 SHALL drive block registered, =1 exactly while in BLOCKED; rises at the edge on which raw was sampled high for the threshold-th consecutive time.
REQ-021 With threshold 1, block SHALL follow raw with one cycle latency.
REQ-022 Counter SHALL saturate at all-ones and never wrap; threshold sampled every cycle, a change mid-COUNT compares against the new value.
REQ-023 block_sticky SHALL set on entry to BLOCKED and hold until clear; clear and entry on same edge -> set wins.
REQ-024 episode_cnt SHALL increment on each IDLE/COUNT->BLOCKED transition, saturate at 255, zero on clear; simultaneous clear and entry -> value 1.

Reset
REQ-025 On reset SHALL go to IDLE, counter=0, block=0, block_sticky=0, src_mask=0, episode_cnt=0; reset overrides clear and raw.
REQ-026 Reset asserted mid-COUNT or in BLOCKED SHALL discard progress; counting restarts from 1 after release.

Configuration
REQ-027 Macro DDS_DDC_DEADLOCK_SNAPSHOT_EN defined: src_mask SHALL capture raw_src on each BLOCKED entry (first episode after clear only), held until clear.
REQ-028 Without DDS_DDC_DEADLOCK_SNAPSHOT_EN: src_mask SHALL be constant 0 and no snapshot register SHALL exist; all other behaviour identical.

Structure
REQ-029 Package dds_ddc_center_dlm_pkg SHALL hold the FSM state enum, EPISODE_W=8 and default parameter constants.
REQ-030 Persistence counter+compare SHALL be sub-module dds_ddc_center_dlm_persist; FSM, sticky and snapshot stay in top.

Verification
REQ-031 threshold=1, axis_block_sigs=01 for 1 cycle -> block high exactly 1 cycle, one edge later; episode_cnt=1.
REQ-032 threshold=4, raw high 3 cycles, low 1, high 4 -> block never high in first burst; high 1 cycle after 4th cycle of second burst.
REQ-033 N_INST=1, inst_block=1 with inst_idle=1 for 10 cycles -> block stays 0; with idle=0 -> block after threshold.
REQ-034 block_sticky set, then clear pulse coincident with new BLOCKED entry -> block_sticky=1, episode_cnt=1.
REQ-035 SNAPSHOT_EN, threshold=2, axis=10 then inst blocked -> src_mask=010 (N_AXIS=2), unchanged by later episodes until clear.
REQ-036 300 separate episodes -> episode_cnt=255; reset in BLOCKED -> all outputs 0 next cycle.
